// File: rtl/computer_pkg.sv
// Shared definitions for the instruction store: control FSM states and the halt opcode.
package computer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Halt opcode is "all ones"; users slice the low OPC_W bits for their opcode width.
    localparam logic [31:0] HALT_OPC_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/inst_mem.sv
// Instruction storage array: synchronous write, asynchronous read.
// With IR_PARITY_EN defined, an even-parity bit is kept per word and checked on read.
module inst_mem #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INST_W-1:0] rdata,
    output logic              par_ok
);

    localparam int DEPTH = 2 ** ADDR_W;

    // No reset on the array so program contents survive RESET and mode changes.
    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

`ifdef IR_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[waddr] <= ^wdata;
        end
    end

    assign par_ok = ((^rdata) == par_mem[raddr]);
`else
    assign par_ok = 1'b1;
`endif

endmodule

// File: rtl/instruction_store.sv
// Instruction store with program/run modes and an IDLE/FETCH/EXEC/HALT sequencer.
// Optional parity protection of stored words is enabled by defining IR_PARITY_EN.
module instruction_store
    import computer_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int INST_W = 8,
    parameter int OPC_W  = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    PRGM,
    input  logic                    WE,
    input  logic [ADDR_W-1:0]       ADDR_IN,
    input  logic [INST_W-1:0]       INST,
    input  logic                    ADV,
    input  logic                    JMP,
    input  logic [ADDR_W-1:0]       JMP_ADDR,
    output logic [OPC_W-1:0]        INST_OUT,
    output logic [INST_W-OPC_W-1:0] ADDR_OUT,
    output logic [ADDR_W-1:0]       PC_OUT,
    output logic                    VALID,
    output logic                    HALTED,
    output logic                    PAR_ERR
);

    localparam logic [OPC_W-1:0] HALT_OPC = HALT_OPC_WORD[OPC_W-1:0];

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [INST_W-1:0] ir;
    logic [INST_W-1:0] ir_next;
    logic [INST_W-1:0] rd_word;
    logic              par_ok;

    inst_mem #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_mem (
        .clk    (CLK),
        .we     (PRGM & WE),
        .waddr  (ADDR_IN),
        .wdata  (INST),
        .raddr  (pc),
        .rdata  (rd_word),
        .par_ok (par_ok)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    // Program mode wins over every run state; a parity fault outranks the halt opcode.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        if (PRGM) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    pc_next    = '0;
                    state_next = FETCH;
                end
                FETCH: begin
                    ir_next = rd_word;
                    if (!par_ok) begin
                        state_next = HALT;
                    end else if (rd_word[INST_W-1 -: OPC_W] == HALT_OPC) begin
                        state_next = HALT;
                    end else begin
                        state_next = EXEC;
                    end
                end
                EXEC: begin
                    if (JMP) begin
                        pc_next    = JMP_ADDR;
                        state_next = FETCH;
                    end else if (ADV) begin
                        pc_next    = pc + ADDR_W'(1);
                        state_next = FETCH;
                    end
                end
                HALT: begin
                    state_next = HALT;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

`ifdef IR_PARITY_EN
    logic par_err;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            par_err <= 1'b0;
        end else if (PRGM) begin
            par_err <= 1'b0;
        end else if (state == FETCH && !par_ok) begin
            par_err <= 1'b1;
        end
    end

    assign PAR_ERR = par_err;
`else
    assign PAR_ERR = 1'b0;
`endif

    assign INST_OUT = ir[INST_W-1 -: OPC_W];
    assign ADDR_OUT = ir[INST_W-OPC_W-1:0];
    assign PC_OUT   = pc;
    assign VALID    = (state == EXEC);
    assign HALTED   = (state == HALT);

endmodule

// File: doc/instruction_store.md
INSTRUCTION_STORE -- requirements
Module: instruction_store

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning address width; store depth is 2**ADDR_W words.
REQ-002 SHALL have parameter INST_W, default 8, meaning instruction word width.
REQ-003 SHALL have parameter OPC_W, default 4, meaning opcode field width (upper bits of a word); operand is the lower INST_W-OPC_W bits.
REQ-004 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-005 SHALL have port RESET  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port PRGM  in  1  program mode; high = load, low = run.
REQ-007 SHALL have port WE  in  1  write strobe, valid only in program mode.
REQ-008 SHALL have port ADDR_IN  in  ADDR_W  program-mode write address.
REQ-009 SHALL have port INST  in  INST_W  program-mode write data.
REQ-010 SHALL have port ADV  in  1  advance request from control unit: PC+1.
REQ-011 SHALL have port JMP  in  1  jump request: PC <= JMP_ADDR.
REQ-012 SHALL have port JMP_ADDR  in  ADDR_W  jump target.
REQ-013 SHALL have port INST_OUT  out  OPC_W  opcode of the held instruction.
REQ-014 SHALL have port ADDR_OUT  out  INST_W-OPC_W  operand of the held instruction.
REQ-015 SHALL have port PC_OUT  out  ADDR_W  address of the held instruction.
REQ-016 SHALL have ports VALID  out  1 (held instruction valid), HALTED  out  1 (halt state) and PAR_ERR  out  1 (parity fault).

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, EXEC, HALT.
REQ-018 SHALL be in IDLE whenever PRGM=1, from any state, on the next edge.
REQ-019 SHALL write INST to mem[ADDR_IN] on an edge with PRGM=1 and WE=1; WE with PRGM=0 is ignored.
REQ-020 SHALL, in IDLE with PRGM=0, load PC=0 and go to FETCH.
REQ-021 SHALL, in FETCH, load IR from mem[PC] (combinational read) and go to EXEC; VALID=1 exactly in EXEC.
REQ-022 SHALL, in EXEC, hold IR/PC until JMP or ADV is sampled, then update PC and go to FETCH; 2-cycle latency from request to a new VALID instruction.
REQ-023 SHALL give JMP priority over ADV when both are high.
REQ-024 SHALL wrap PC from 2**ADDR_W-1 to 0 on ADV.
REQ-025 SHALL go to HALT instead of EXEC when the fetched opcode is all ones; in HALT: HALTED=1, VALID=0, ADV/JMP ignored, IR shows the halt word; exit only via PRGM or RESET.
REQ-026 SHALL keep memory contents unchanged across mode changes and RESET.

Reset
REQ-027 SHALL on RESET clear IR, PC, INST_OUT, ADDR_OUT, PC_OUT, VALID, HALTED and PAR_ERR to 0 and force IDLE, independent of CLK.
REQ-028 SHALL abandon any fetch or EXEC in progress when RESET is asserted mid-operation; run restarts from PC=0.

Configuration
REQ-029 SHALL, with IR_PARITY_EN defined, store an even-parity bit per word on write, check it in FETCH, and on mismatch set PAR_ERR=1 (sticky until PRGM or RESET) and enter HALT.
REQ-030 SHALL, without IR_PARITY_EN, store no parity bit and tie PAR_ERR to 0.

Structure
REQ-031 SHALL take the FSM state enum and the halt-opcode constant (all ones) from shared package computer_pkg.
REQ-032 SHALL place the storage array, plus optional parity, in one sub-module inst_mem (sync write, async read).

Verification
REQ-033 RESET=1 mid-EXEC -> all outputs 0 immediately, state IDLE.
REQ-034 PRGM=1, WE=1: mem[0]=0x3A, mem[10]=0xC5; drop PRGM -> 2 edges later VALID=1, INST_OUT=0x3, ADDR_OUT=0xA, PC_OUT=0.
REQ-035 Run to PC=15 with mem[15]=0x12, ADV -> PC_OUT=0 after 2 cycles.
REQ-036 In EXEC, ADV=1, JMP=1, JMP_ADDR=10 -> PC_OUT=10, INST_OUT=0xC, ADDR_OUT=0x5.
REQ-037 mem[1]=0xF0, ADV from PC=0 -> HALTED=1, VALID=0; further ADV has no effect; PRGM pulse -> IDLE, HALTED=0.
REQ-038 IR_PARITY_EN: force parity bit of mem[0] inverted, release PRGM -> PAR_ERR=1, HALTED=1, VALID=0.
